// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and 640x480@60 defaults for the raster generator.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FP_DEF      = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BP_DEF      = 48;
    localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FP_DEF      = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BP_DEF      = 33;
    localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

    // True while pos lies in the half-open window [lo, hi).
    function automatic logic sync_active(input coord_t pos, input coord_t lo, input coord_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register for the hs/vs pair, advanced only on pixel enables.
// Stages reset to the idle sync level so no spurious pulse follows reset.
module vga_sync_delay
    import vga_timing_pkg::*;
#(
    parameter int    DEPTH   = 1,
    parameter sync_t RST_VAL = '0
) (
    input  logic  clk_i,
    input  logic  rst_i,
    input  logic  ce_i,
    input  sync_t sync_i,
    output sync_t sync_o
);

    sync_t [DEPTH-1:0] pipe_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pipe_q <= {DEPTH{RST_VAL}};
        end else if (ce_i) begin
            pipe_q[0] <= sync_i;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign sync_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY scan, blank, hs/vs and line/frame pulses, all registered.
// Define VGA_SYNC_PIPE_EN to delay hs/vs by SYNC_DLY pixel advances.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE       = H_VISIBLE_DEF,
    parameter int H_FP            = H_FP_DEF,
    parameter int H_SYNC          = H_SYNC_DEF,
    parameter int H_BP            = H_BP_DEF,
    parameter int V_VISIBLE       = V_VISIBLE_DEF,
    parameter int V_FP            = V_FP_DEF,
    parameter int V_SYNC          = V_SYNC_DEF,
    parameter int V_BP            = V_BP_DEF,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int SYNC_DLY        = 1
) (
    input  logic               vga_clk,
    input  logic               reset,
    input  logic               pix_ce,
    output logic [COORD_W-1:0] DrawX,
    output logic [COORD_W-1:0] DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               frame_start,
    output logic               line_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counters");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $error("vga_timing_gen: porch and sync widths must be at least 1");
    end

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic   SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic   SYNC_IDLE = ~SYNC_ON;

    coord_t x_q, x_d, y_q, y_d;
    logic   blank_q, blank_d;
    logic   hs_q, hs_d, vs_q, vs_d;
    logic   fs_q, fs_d, ls_q, ls_d;

    // Status is derived from the next position so every output describes the same pixel.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fs_d    = 1'b0;
        ls_d    = 1'b0;
        if (pix_ce) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            blank_d = (x_d < H_VIS_C) && (y_d < V_VIS_C);
            hs_d    = sync_active(x_d, HS_START, HS_END) ? SYNC_ON : SYNC_IDLE;
            vs_d    = sync_active(y_d, VS_START, VS_END) ? SYNC_ON : SYNC_IDLE;
            ls_d    = (x_d == '0);
            fs_d    = (x_d == '0) && (y_d == '0);
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            blank_q <= 1'b0;
            hs_q    <= SYNC_IDLE;
            vs_q    <= SYNC_IDLE;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            fs_q    <= fs_d;
            ls_q    <= ls_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign blank       = blank_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

`ifdef VGA_SYNC_PIPE_EN
    if (SYNC_DLY < 1 || SYNC_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: SYNC_DLY must be within 1..4");
    end

    sync_t sync_dly;

    vga_sync_delay #(
        .DEPTH   (SYNC_DLY),
        .RST_VAL (sync_t'({SYNC_IDLE, SYNC_IDLE}))
    ) u_sync_dly (
        .clk_i  (vga_clk),
        .rst_i  (reset),
        .ce_i   (pix_ce),
        .sync_i ({hs_q, vs_q}),
        .sync_o (sync_dly)
    );

    assign hs = sync_dly.hs;
    assign vs = sync_dly.vs;
`else
    localparam int unused_sync_dly = SYNC_DLY;

    assign hs = hs_q;
    assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a 640x480 instance and a tiny-geometry instance share stimulus
// and are checked each cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int SDLY = 2;
`ifdef VGA_SYNC_PIPE_EN
    localparam int D = SDLY;
`else
    localparam int D = 0;
`endif

    typedef struct packed {
        int hv; int hfp; int hs; int hbp;
        int vv; int vfp; int vs; int vbp;
    } geom_t;

    localparam geom_t GD = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam geom_t GS = '{20, 3, 4, 5, 12, 2, 2, 3};
    localparam int TOT_D = 800 * 525;
    localparam int TOT_S = 32 * 19;

    typedef struct {
        bit r; bit ce;
        int ex; int ey;
        bit eb; bit efs; bit els; bit ehs; bit evs;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       pix_ce;
    logic [9:0] dx, dy, sx, sy;
    logic       db, dhs, dvs, dfs, dls;
    logic       sb, shs, svs, sfs, sls;

    int n_cmp = 0;
    int n_bad = 0;
    int nd    = TOT_D - 1;
    int ns    = TOT_S - 1;
    int cyc   = 0;

    vga_timing_gen #(.SYNC_DLY(SDLY)) u_dut (
        .vga_clk(clk), .reset(rst), .pix_ce(pix_ce),
        .DrawX(dx), .DrawY(dy), .blank(db), .hs(dhs), .vs(dvs),
        .frame_start(dfs), .line_start(dls)
    );

    vga_timing_gen #(
        .H_VISIBLE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .SYNC_ACTIVE_LOW(1), .SYNC_DLY(SDLY)
    ) u_small (
        .vga_clk(clk), .reset(rst), .pix_ce(pix_ce),
        .DrawX(sx), .DrawY(sy), .blank(sb), .hs(shs), .vs(svs),
        .frame_start(sfs), .line_start(sls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Position index n counts pixel advances within a frame; hs/vs come from n-D.
    function automatic logic [24:0] exp_out(input geom_t g, input int n, input bit adv);
        int ht, vt, tot, x, y, nq, xq, yq;
        bit b, h, v;
        ht  = g.hv + g.hfp + g.hs + g.hbp;
        vt  = g.vv + g.vfp + g.vs + g.vbp;
        tot = ht * vt;
        x   = n % ht;
        y   = n / ht;
        b   = (x < g.hv) && (y < g.vv);
        nq  = (n - D + tot) % tot;
        xq  = nq % ht;
        yq  = nq / ht;
        h   = !((xq >= g.hv + g.hfp) && (xq < g.hv + g.hfp + g.hs));
        v   = !((yq >= g.vv + g.vfp) && (yq < g.vv + g.vfp + g.vs));
        return {x[9:0], y[9:0], b, h, v, adv && (n == 0), adv && (x == 0)};
    endfunction

    function automatic logic [24:0] pack_d();
        return {dx, dy, db, dhs, dvs, dfs, dls};
    endfunction

    function automatic logic [24:0] pack_s();
        return {sx, sy, sb, shs, svs, sfs, sls};
    endfunction

    // Inputs change just after the falling edge; outputs are sampled on the falling edge.
    task automatic step(input bit r, input bit ce);
        bit adv;
        rst    = r;
        pix_ce = ce;
        @(posedge clk);
        adv = !r && ce;
        if (r) begin
            nd = TOT_D - 1;
            ns = TOT_S - 1;
        end else if (ce) begin
            nd = (nd + 1) % TOT_D;
            ns = (ns + 1) % TOT_S;
        end
        cyc++;
        @(negedge clk);
        check("model_vga", pack_d(), exp_out(GD, nd, adv));
        check("model_small", pack_s(), exp_out(GS, ns, adv));
    endtask

    vec_t tbl[9];
    int   ls_first, ls_second, x, vs_cnt, fs_cnt, period;
    bit   found, ph;

    initial begin
        rst    = 1'b1;
        pix_ce = 1'b0;
        tbl[0] = '{1, 1, 799, 524, 0, 0, 0, 1, 1};
        tbl[1] = '{0, 0, 799, 524, 0, 0, 0, 1, 1};
        tbl[2] = '{0, 1,   0,   0, 1, 1, 1, 1, 1};
        tbl[3] = '{0, 1,   1,   0, 1, 0, 0, 1, 1};
        tbl[4] = '{0, 0,   1,   0, 1, 0, 0, 1, 1};
        tbl[5] = '{1, 1, 799, 524, 0, 0, 0, 1, 1};
        tbl[6] = '{0, 1,   0,   0, 1, 1, 1, 1, 1};
        tbl[7] = '{0, 0,   0,   0, 1, 0, 0, 1, 1};
        tbl[8] = '{0, 1,   1,   0, 1, 0, 0, 1, 1};

        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].ce);
            check($sformatf("vec%0d", i), pack_d(),
                  {10'(tbl[i].ex), 10'(tbl[i].ey), tbl[i].eb, tbl[i].ehs, tbl[i].evs,
                   tbl[i].efs, tbl[i].els});
        end

        // One full 640x480 line plus one more, checking hs edges, blanking and line period.
        ls_first  = -1;
        ls_second = -1;
        for (int i = 1; i <= 1600; i++) begin
            step(1'b0, 1'b1);
            x = (1 + i) % 800;
            if (x == 655 + D) check("hs_before_sync", 32'(dhs), 1);
            if (x == 656 + D) check("hs_sync_first", 32'(dhs), 0);
            if (x == 751 + D) check("hs_sync_last", 32'(dhs), 0);
            if (x == 752 + D) check("hs_after_sync", 32'(dhs), 1);
            if (x == 639) check("blank_last_visible", 32'(db), 1);
            if (x == 640 || x == 799) check("blank_hporch", 32'(db), 0);
            if (dls) begin
                if (ls_first < 0) ls_first = cyc;
                else if (ls_second < 0) ls_second = cyc;
            end
        end
        check("line_start_period", 32'(ls_second - ls_first), 800);

        // Whole frame on the small geometry.
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            step(1'b0, 1'b1);
            if (sfs) found = 1'b1;
        end
        check("small_frame_found", 32'(found), 1);
        vs_cnt = 0;
        fs_cnt = 0;
        for (int k = 1; k <= TOT_S; k++) begin
            step(1'b0, 1'b1);
            if (!svs) vs_cnt++;
            if (k < TOT_S && sfs) fs_cnt++;
            if (k == TOT_S - 1) check("small_pre_wrap", {sx, sy}, {10'd31, 10'd18});
            if (k == TOT_S) begin
                check("small_frame_period", 32'(sfs), 1);
                check("small_wrap_origin", {sx, sy}, 0);
            end
        end
        check("small_vs_cycles", vs_cnt, 2 * 32);
        check("small_fs_extra", fs_cnt, 0);

        // Alternating pixel enable doubles the frame period; pulses stay one clock.
        ph    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1400 && !found; i++) begin
            step(1'b0, ph);
            ph = !ph;
            if (sfs) found = 1'b1;
        end
        check("toggle_fs_found", 32'(found), 1);
        period = 0;
        found  = 1'b0;
        for (int i = 1; i <= 3000 && !found; i++) begin
            step(1'b0, ph);
            ph = !ph;
            if (i == 1) check("fs_one_clock", 32'(sfs), 0);
            if (sfs) begin
                found  = 1'b1;
                period = i;
            end
        end
        check("toggle_frame_period", period, 2 * TOT_S);

        // Asynchronous reset in the middle of a line.
        for (int i = 0; i < 800 && (nd % 800) != 300; i++) step(1'b0, 1'b1);
        check("pre_reset_x", 32'(dx), 300);
        #1 rst = 1'b1;
        #1;
        nd = TOT_D - 1;
        ns = TOT_S - 1;
        check("async_reset_vga", 32'(pack_d()),
              {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("async_reset_small", 32'(pack_s()),
              {10'd31, 10'd18, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("resume_origin", 32'(pack_d()),
              {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1});

        // Random enables with occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA raster timing that the full-screen sprite/background renderers consume.
- Produces DrawX/DrawY scan coordinates, the display-active flag `blank` (high = visible pixel), and hsync/vsync for the monitor.
- Sits between the pixel clock source and every screen renderer (start, level, end screens), and drives the VGA connector's sync pins.
- Supports a pixel clock-enable so it can run from a faster system clock.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels); H_TOTAL = 800
- V_VISIBLE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines); V_TOTAL = 525
- SYNC_ACTIVE_LOW, 1, 1 = hs/vs pulse low, 0 = pulse high
- SYNC_DLY, 1, hs/vs delay in pixel advances; used only with VGA_SYNC_PIPE_EN, legal range 1..4

Ports:
- vga_clk  input  1  pixel/system clock
- reset  input  1  asynchronous, active-high reset
- pix_ce  input  1  pixel advance enable; tie high for a native 25 MHz clock
- DrawX  output  10  current column, 0..H_TOTAL-1
- DrawY  output  10  current line, 0..V_TOTAL-1
- blank  output  1  1 when DrawX<H_VISIBLE and DrawY<V_VISIBLE
- hs  output  1  horizontal sync
- vs  output  1  vertical sync
- frame_start  output  1  one-clock pulse when the raster enters (0,0)
- line_start  output  1  one-clock pulse when DrawX enters 0

Behaviour:
- All outputs are registered and mutually aligned: blank/hs/vs/pulses describe the same pixel as DrawX/DrawY in the same cycle.
- Reset (async assert, sync effect on release):
  - DrawX=H_TOTAL-1, DrawY=V_TOTAL-1.
  - blank=0, frame_start=0, line_start=0.
  - hs and vs at their inactive level.
- First rising edge with pix_ce=1 after reset release advances to (0,0) with blank=1, frame_start=1, line_start=1.
- Advance rule (only on an edge with pix_ce=1):
  - DrawX increments; at H_TOTAL-1 it wraps to 0.
  - DrawY increments only on that wrap; at V_TOTAL-1 it wraps to 0 at the same edge as DrawX.
- pix_ce=0: every output holds, except frame_start and line_start, which are forced to 0. Each pulse lasts exactly one vga_clk cycle, never one pixel period.
- hs is active for DrawX in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), i.e. 656..751.
- vs is active for DrawY in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC), i.e. 490..491, for whole lines. vs changes only together with a DrawY change.
- Width rules:
  - Comparisons are unsigned.
  - Counters are 10 bits; H_TOTAL and V_TOTAL must be ≤1024 (elaboration assertion).
  - Each porch and sync parameter must be ≥1 (elaboration assertion).
- Reset mid-frame: outputs take reset values immediately, asynchronously; the next frame starts at (0,0) as after power-up.
- reset asserted together with pix_ce: reset wins.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- Defined:
  - hs and vs pass through a SYNC_DLY-stage delay line advanced on pix_ce. This matches renderers that register colour one pixel after DrawX.
  - The delay stages reset to the inactive level.
  - DrawX, DrawY, blank, frame_start and line_start stay undelayed.
- Undefined: hs and vs are aligned with DrawX/DrawY as specified above, and SYNC_DLY is ignored.

Decomposition:
- Package vga_timing_pkg holds:
  - default 640x480@60 constants (H_*/V_*/totals);
  - COORD_W=10;
  - typedef coord_t (logic [COORD_W-1:0]);
  - a function computing the sync-active flag from a position and window bounds.
- Sub-module vga_sync_delay: a parameterised shift register with pix_ce and reset-to-inactive, instantiated only under VGA_SYNC_PIPE_EN.

Test Plan:
- Release reset with pix_ce=1 → first edge DrawX=0, DrawY=0, blank=1, frame_start=1, line_start=1; the next edge gives DrawX=1 with frame_start=0.
- Run one line, pix_ce=1, SYNC_ACTIVE_LOW=1:
  - hs=1 at DrawX=655, hs=0 for 656..751, hs=1 at 752;
  - blank=0 for DrawX 640..799;
  - line_start period = 800 clocks.
- Run a full frame:
  - vs=0 exactly while DrawY=490..491 (1600 clocks);
  - DrawY wraps 524→0 on the same edge DrawX wraps 799→0;
  - frame_start period = 420000 clocks.
- pix_ce toggling 1,0,1,0…:
  - outputs hold on ce=0 cycles;
  - frame_start stays one clock wide;
  - frame period = 840000 clocks.
- Assert reset at DrawX=300, DrawY=200 for 3 clocks:
  - outputs immediately read 799/524, blank=0, hs=vs=1;
  - after release, counting resumes from (0,0).
- VGA_SYNC_PIPE_EN defined, SYNC_DLY=2 → hs falls at DrawX=658 and rises at DrawX=754; DrawX and blank timing are unchanged from the undelayed case.
